shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched_pkg.sv | 19 +
 rtl/shift_gate.sv | 17 +
 rtl/shift_rr_arb.sv | 17 +
 rtl/shift_sched.sv | 120 ++++++++++++
 tb/tb_shift_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift scheduler.
package shift_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [3:0] a;
        logic [1:0] amt;
        logic       dir;
    } req_t;

endpackage

// File: rtl/shift_gate.sv
// 4-bit logical shifter: zero fill both ways, bits shifted out are dropped.
module shift_gate
    import shift_sched_pkg::*;
(
    input  logic [3:0] a,
    input  logic [1:0] amt,
    input  logic       dir,
    output logic [3:0] y
);

    // Pure combinational shift; amt 0 passes the operand through.
    always_comb begin
        if (dir == DIR_RIGHT) y = a >> amt;
        else                  y = a << amt;
    end

endmodule

// File: rtl/shift_rr_arb.sv
// Two-way arbiter: fixed priority to requester 0, or round-robin on last_grant.
module shift_rr_arb (
    input  logic [1:0] valid,
    input  logic       prio_fixed,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Contention goes to requester 0 in fixed mode, else to whoever did not win last.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (prio_fixed || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// Shift scheduler: arbitrates two requesters onto one shared shifter.
// IDLE accepts one op, EXEC runs the shifter, RESP holds the result.
// Optional macro SHIFT_SCHED_PERF_EN adds saturating per-requester accept counters.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [1:0] req0_amt,
    input  logic       req0_dir,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [1:0] req1_amt,
    input  logic       req1_dir,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_y,
    output logic       rsp_id,
`ifdef SHIFT_SCHED_PERF_EN
    output logic [7:0] perf_cnt0,
    output logic [7:0] perf_cnt1,
`endif
    output logic       busy
);

    state_t     state;
    logic       last_grant;
    logic [1:0] grant;
    logic       accept;
    req_t       req0, req1, sel, op_q;
    logic       id_q;
    logic [3:0] sh_y;

    assign req0 = '{a: req0_a, amt: req0_amt, dir: req0_dir};
    assign req1 = '{a: req1_a, amt: req1_amt, dir: req1_dir};
    assign sel  = grant[1] ? req1 : req0;

    shift_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .prio_fixed (PRIO_FIXED != 0),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is a same-cycle handshake, so it is decoded from the registered state.
    assign accept     = (state == ST_IDLE) && (grant != 2'b00) && !rst;
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    shift_gate u_gate (
        .a   (op_q.a),
        .amt (op_q.amt),
        .dir (op_q.dir),
        .y   (sh_y)
    );

    // Main FSM: latch on accept, register shifter output, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_y      <= 4'd0;
            rsp_id     <= 1'b0;
            op_q       <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= sel;
                        id_q       <= grant[1];
                        last_grant <= grant[1];
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y     <= sh_y;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_SCHED_PERF_EN
    // Saturating accept counters, one per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt0 <= 8'd0;
            perf_cnt1 <= 8'd0;
        end else begin
            if (req0_ready && perf_cnt0 != 8'hFF) perf_cnt0 <= perf_cnt0 + 8'd1;
            if (req1_ready && perf_cnt1 != 8'hFF) perf_cnt1 <= perf_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: a round-robin and a fixed-priority instance run in lockstep.
module tb_shift_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_a, req1_a;
    logic [1:0] req0_amt, req1_amt;
    logic       req0_dir, req1_dir;

    logic       r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_busy;
    logic [3:0] r_rsp_y;
    logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_busy;
    logic [3:0] f_rsp_y;
`ifdef SHIFT_SCHED_PERF_EN
    logic [7:0] r_perf0, r_perf1, f_perf0, f_perf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sched #(.PRIO_FIXED(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_a(req0_a),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_a(req1_a),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready), .rsp_y(r_rsp_y), .rsp_id(r_rsp_id),
`ifdef SHIFT_SCHED_PERF_EN
        .perf_cnt0(r_perf0), .perf_cnt1(r_perf1),
`endif
        .busy(r_busy)
    );

    shift_sched #(.PRIO_FIXED(1)) u_fix (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_y(f_rsp_y), .rsp_id(f_rsp_id),
`ifdef SHIFT_SCHED_PERF_EN
        .perf_cnt0(f_perf0), .perf_cnt1(f_perf1),
`endif
        .busy(f_busy)
    );

    typedef struct {
        logic       port;
        logic [3:0] a;
        logic [1:0] amt;
        logic       dir;
        logic [3:0] y;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Single-requester op through accept, exec, resp and handoff.
    task automatic run_op(input vec_t v, input string tag);
        if (v.port) begin
            req1_valid = 1'b1; req1_a = v.a; req1_amt = v.amt; req1_dir = v.dir;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_amt = v.amt; req0_dir = v.dir;
        end
        #1;
        chk({tag, " ready"}, v.port ? r_req1_ready : r_req0_ready, 1);
        chk({tag, " other_ready"}, v.port ? r_req0_ready : r_req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, " exec_valid"}, r_rsp_valid, 0);
        chk({tag, " exec_busy"}, r_busy, 1);
        tick();
        chk({tag, " rsp_valid"}, r_rsp_valid, 1);
        chk({tag, " rsp_y"}, r_rsp_y, v.y);
        chk({tag, " rsp_id"}, r_rsp_id, v.port);
        chk({tag, " fix_rsp_y"}, f_rsp_y, v.y);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " idle_busy"}, r_busy, 0);
        chk({tag, " idle_valid"}, r_rsp_valid, 0);
    endtask

    initial begin
        vt[0] = '{port: 1'b0, a: 4'b1010, amt: 2'b01, dir: 1'b0, y: 4'b0100};
        vt[1] = '{port: 1'b1, a: 4'b1010, amt: 2'b10, dir: 1'b1, y: 4'b0010};
        vt[2] = '{port: 1'b1, a: 4'b1011, amt: 2'b11, dir: 1'b0, y: 4'b1000};
        vt[3] = '{port: 1'b0, a: 4'b0110, amt: 2'b00, dir: 1'b1, y: 4'b0110};
        vt[4] = '{port: 1'b0, a: 4'b1111, amt: 2'b11, dir: 1'b1, y: 4'b0001};
        vt[5] = '{port: 1'b1, a: 4'b1001, amt: 2'b01, dir: 1'b1, y: 4'b0100};
        vt[6] = '{port: 1'b0, a: 4'b0111, amt: 2'b10, dir: 1'b0, y: 4'b1100};

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_a = 4'd0; req0_amt = 2'd0; req0_dir = 1'b0;
        req1_a = 4'd0; req1_amt = 2'd0; req1_dir = 1'b0;
        #2;
        chk("reset req0_ready", r_req0_ready, 0);
        chk("reset req1_ready", r_req1_ready, 0);
        chk("reset rsp_valid", r_rsp_valid, 0);
        chk("reset busy", r_busy, 0);
        chk("reset rsp_y", r_rsp_y, 0);
        chk("reset rsp_id", r_rsp_id, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_op(vt[i], $sformatf("vec%0d", i));

        // Contention: round-robin alternates from id 0, fixed always picks 0.
        pulse_reset();
        req0_valid = 1'b1; req0_a = 4'b0001; req0_amt = 2'd1; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b1000; req1_amt = 2'd1; req1_dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("arb%0d rr_ready0", k), r_req0_ready, (k % 2 == 0));
            chk($sformatf("arb%0d rr_ready1", k), r_req1_ready, (k % 2 == 1));
            chk($sformatf("arb%0d fix_ready0", k), f_req0_ready, 1);
            tick();
            tick();
            chk($sformatf("arb%0d rr_id", k), r_rsp_id, k % 2);
            chk($sformatf("arb%0d rr_y", k), r_rsp_y, (k % 2 == 0) ? 4'b0010 : 4'b0100);
            chk($sformatf("arb%0d fix_id", k), f_rsp_id, 0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Consumer stall in RESP with a second request waiting.
        pulse_reset();
        req0_valid = 1'b1; req0_a = 4'b1010; req0_amt = 2'd1; req0_dir = 1'b0;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b0011; req1_amt = 2'd2; req1_dir = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stall%0d y", c), r_rsp_y, 4'b0100);
            chk($sformatf("stall%0d id", c), r_rsp_id, 0);
            chk($sformatf("stall%0d valid", c), r_rsp_valid, 1);
            chk($sformatf("stall%0d req1_ready", c), r_req1_ready, 0);
            chk($sformatf("stall%0d busy", c), r_busy, 1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("stall release busy", r_busy, 0);
        chk("stall waiting req1_ready", r_req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("stall waiting rsp_valid", r_rsp_valid, 1);
        chk("stall waiting id", r_rsp_id, 1);
        chk("stall waiting y", r_rsp_y, 4'b1100);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset while in RESP discards the response.
        req0_valid = 1'b1; req0_a = 4'b0101; req0_amt = 2'd0; req0_dir = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("rstresp pre valid", r_rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rstresp valid", r_rsp_valid, 0);
        chk("rstresp busy", r_busy, 0);
        chk("rstresp y", r_rsp_y, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rstresp quiet%0d", c), r_rsp_valid, 0);
        end
        run_op(vt[2], "post_reset");

`ifdef SHIFT_SCHED_PERF_EN
        begin
            int acc = 0;
            int cyc = 0;
            pulse_reset();
            chk("perf reset cnt0", r_perf0, 0);
            req0_valid = 1'b1; req0_a = 4'b0001; req0_amt = 2'd0; req0_dir = 1'b0;
            rsp_ready = 1'b1;
            while (acc < 300 && cyc < 2000) begin
                if (r_req0_ready) acc++;
                tick();
                cyc++;
            end
            req0_valid = 1'b0;
            rsp_ready = 1'b0;
            if (acc < 300) chk("perf timeout", acc, 300);
            tick();
            chk("perf cnt0", r_perf0, 255);
            chk("perf cnt1", r_perf1, 0);
            chk("perf fix cnt0", f_perf0, 255);
            chk("perf fix cnt1", f_perf1, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
